// File: rtl/keccak_nonce_dispatcher_if.sv
// Job, hasher and result signals of keccak_nonce_dispatcher, grouped as one bundle.
// The abort input is present only when KECCAK_DISPATCH_ABORT_EN is defined.
interface keccak_nonce_dispatcher_if #(
    parameter int HDR_WIDTH   = 224,
    parameter int NONCE_WIDTH = 32
);
    logic                             job_valid;
    logic                             job_ready;
    logic [HDR_WIDTH-1:0]             job_header;
    logic [NONCE_WIDTH-1:0]           job_nonce_start;
    logic [NONCE_WIDTH-1:0]           job_nonce_count;
    logic [63:0]                      job_target;
    logic [HDR_WIDTH+NONCE_WIDTH-1:0] hash_in;
    logic                             hash_read;
    logic [255:0]                     hash_out;
    logic                             hash_write;
    logic                             found_valid;
    logic                             found_ready;
    logic [NONCE_WIDTH-1:0]           found_nonce;
    logic [63:0]                      found_hash_hi;
    logic                             busy;
    logic                             done;
    logic [7:0]                       drop_count;
`ifdef KECCAK_DISPATCH_ABORT_EN
    logic                             abort;
`endif

    modport slave (
        input  job_valid, job_header, job_nonce_start, job_nonce_count, job_target,
        output job_ready,
        output hash_in, hash_read,
        input  hash_out, hash_write,
        output found_valid, found_nonce, found_hash_hi,
        input  found_ready,
        output busy, done, drop_count
`ifdef KECCAK_DISPATCH_ABORT_EN
        , input abort
`endif
    );

    modport master (
        output job_valid, job_header, job_nonce_start, job_nonce_count, job_target,
        input  job_ready,
        input  hash_in, hash_read,
        output hash_out, hash_write,
        input  found_valid, found_nonce, found_hash_hi,
        output found_ready,
        input  busy, done, drop_count
`ifdef KECCAK_DISPATCH_ABORT_EN
        , output abort
`endif
    );
endinterface

// File: rtl/keccak_nonce_dispatcher.sv
// Feeds nonces to a pipelined Keccak-f[800] hasher, pairs returned digests with their nonces
// and reports hits below the target. Define KECCAK_DISPATCH_ABORT_EN to add the abort input.
module keccak_nonce_dispatcher #(
    parameter int THROUGHPUT  = 10,
    parameter int HDR_WIDTH   = 224,
    parameter int NONCE_WIDTH = 32,
    parameter int TAG_DEPTH   = 8
) (
    input logic clk,
    input logic rst,
    keccak_nonce_dispatcher_if.slave bus
);
    localparam int SLOT_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(THROUGHPUT - 1);
    localparam logic [TAG_AW:0]   TAG_FULL  = (TAG_AW + 1)'(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                           state_reg;
    logic [SLOT_W-1:0]                slot_reg;
    logic [HDR_WIDTH-1:0]             header_reg;
    logic [NONCE_WIDTH-1:0]           nonce_reg;
    logic [NONCE_WIDTH-1:0]           remaining_reg;
    logic [63:0]                      target_reg;
    logic [HDR_WIDTH+NONCE_WIDTH-1:0] hash_in_reg;
    logic                             hash_read_reg;
    logic                             job_ready_reg;
    logic                             done_reg;
    logic [7:0]                       drop_reg;
    logic [TAG_AW:0]                  tag_wr_reg, tag_rd_reg;
    logic [1:0]                       found_wr_reg, found_rd_reg;

    logic [NONCE_WIDTH-1:0] tag_mem [TAG_DEPTH];
    logic [NONCE_WIDTH-1:0] found_nonce_mem [2];
    logic [63:0]            found_hi_mem [2];

    logic abort_in;
`ifdef KECCAK_DISPATCH_ABORT_EN
    assign abort_in = bus.abort;
`else
    assign abort_in = 1'b0;
`endif

    logic unused_hash_lo;
    assign unused_hash_lo = ^bus.hash_out[191:0];

    logic                   accept, slot_edge, issue, tag_empty, tag_full, tag_pop;
    logic                   hit, found_pop, found_full, found_push, drop_evt, found_valid;
    logic [NONCE_WIDTH-1:0] nonce_base, rem_base, pop_nonce;
    logic [HDR_WIDTH-1:0]   hdr_base;
    logic [TAG_AW:0]        tag_count;
    logic [1:0]             found_count;

    assign accept     = (state_reg == IDLE) && bus.job_valid && job_ready_reg;
    assign slot_edge  = (slot_reg == SLOT_LAST);
    assign nonce_base = accept ? bus.job_nonce_start : nonce_reg;
    assign rem_base   = accept ? bus.job_nonce_count : remaining_reg;
    assign hdr_base   = accept ? bus.job_header : header_reg;
    assign tag_count  = tag_wr_reg - tag_rd_reg;
    assign tag_empty  = (tag_count == '0);
    assign tag_full   = (tag_count == TAG_FULL);
    // The first slot of a job is taken on the accepting edge itself so the read lands one cycle later.
    assign issue = !tag_full &&
                   ((accept && bus.job_nonce_count != '0) ||
                    (state_reg == RUN && slot_edge && !abort_in));

    assign tag_pop     = bus.hash_write && !tag_empty;
    assign pop_nonce   = tag_mem[tag_rd_reg[TAG_AW-1:0]];
    assign hit         = tag_pop && (bus.hash_out[255:192] <= target_reg);
    assign found_count = found_wr_reg - found_rd_reg;
    assign found_valid = (found_count != 2'd0);
    assign found_pop   = found_valid && bus.found_ready;
    assign found_full  = (found_count == 2'd2);
    assign found_push  = hit && (!found_full || found_pop);
    assign drop_evt    = (bus.hash_write && tag_empty) || (hit && !found_push);

    always_ff @(posedge clk) begin
        if (issue)
            tag_mem[tag_wr_reg[TAG_AW-1:0]] <= nonce_base;
        if (found_push) begin
            found_nonce_mem[found_wr_reg[0]] <= pop_nonce;
            found_hi_mem[found_wr_reg[0]]    <= bus.hash_out[255:192];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            header_reg    <= '0;
            nonce_reg     <= '0;
            remaining_reg <= '0;
            target_reg    <= '0;
            hash_in_reg   <= '0;
            hash_read_reg <= 1'b0;
            job_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            drop_reg      <= '0;
            tag_wr_reg    <= '0;
            tag_rd_reg    <= '0;
            found_wr_reg  <= '0;
            found_rd_reg  <= '0;
        end else begin
            done_reg      <= 1'b0;
            hash_read_reg <= issue;
            if (issue) begin
                hash_in_reg <= {nonce_base, hdr_base};
                tag_wr_reg  <= tag_wr_reg + 1'b1;
            end
            if (tag_pop)
                tag_rd_reg <= tag_rd_reg + 1'b1;
            if (found_push)
                found_wr_reg <= found_wr_reg + 1'b1;
            if (found_pop)
                found_rd_reg <= found_rd_reg + 1'b1;
            if (drop_evt && drop_reg != 8'hFF)
                drop_reg <= drop_reg + 8'd1;

            case (state_reg)
                IDLE: begin
                    job_ready_reg <= 1'b1;
                    if (accept) begin
                        header_reg    <= bus.job_header;
                        target_reg    <= bus.job_target;
                        slot_reg      <= '0;
                        nonce_reg     <= issue ? nonce_base + NONCE_WIDTH'(1) : nonce_base;
                        remaining_reg <= issue ? rem_base - NONCE_WIDTH'(1) : rem_base;
                        if (bus.job_nonce_count == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            job_ready_reg <= 1'b0;
                            state_reg     <= (issue && rem_base == NONCE_WIDTH'(1)) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    slot_reg <= slot_edge ? '0 : slot_reg + 1'b1;
                    if (abort_in) begin
                        remaining_reg <= '0;
                        state_reg     <= DRAIN;
                    end else if (issue) begin
                        nonce_reg     <= nonce_reg + NONCE_WIDTH'(1);
                        remaining_reg <= remaining_reg - NONCE_WIDTH'(1);
                        if (remaining_reg == NONCE_WIDTH'(1))
                            state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tag_empty && !bus.hash_write) begin
                        state_reg     <= IDLE;
                        done_reg      <= 1'b1;
                        job_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.job_ready     = job_ready_reg;
    assign bus.hash_in       = hash_in_reg;
    assign bus.hash_read     = hash_read_reg;
    assign bus.found_valid   = found_valid;
    assign bus.found_nonce   = found_valid ? found_nonce_mem[found_rd_reg[0]] : '0;
    assign bus.found_hash_hi = found_valid ? found_hi_mem[found_rd_reg[0]] : '0;
    assign bus.busy          = (state_reg != IDLE);
    assign bus.done          = done_reg;
    assign bus.drop_count    = drop_reg;
endmodule

// File: tb/tb_keccak_nonce_dispatcher.sv
// Bench for keccak_nonce_dispatcher: behavioural hasher with fixed latency plus read/found scoreboards.
// Define KECCAK_DISPATCH_ABORT_EN to include the abort scenario.
module tb_keccak_nonce_dispatcher;
    localparam int TP  = 10;
    localparam int HW  = 224;
    localparam int NW  = 32;
    localparam int LAT = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_nonce_dispatcher_if #(.HDR_WIDTH(HW), .NONCE_WIDTH(NW)) dif ();

    keccak_nonce_dispatcher #(
        .THROUGHPUT(TP), .HDR_WIDTH(HW), .NONCE_WIDTH(NW), .TAG_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    typedef struct { int due; logic [31:0] nonce; } pend_t;
    typedef struct { logic [31:0] nonce; logic [63:0] hi; } found_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_count = 0;
    int done_cnt = 0;
    int found_cnt = 0;
    int acc_cyc = 0;
    int rd_base = 0;
    pend_t        pend_q[$];
    logic [31:0]  exp_rd_q[$];
    int           rd_cyc_q[$];
    found_t       exp_found_q[$];
    logic [HW-1:0] cur_hdr = '0;
    logic [31:0]  mon_nonce;
    found_t       mon_found;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] dig(input logic [31:0] n);
        return {n * 32'h9E37_79B1, n ^ 32'h5A5A_5A5A, {6{n ^ 32'h1234_5678}}};
    endfunction

    task automatic push_found(input logic [31:0] n);
        logic [255:0] d;
        d = dig(n);
        exp_found_q.push_back('{n, d[255:192]});
    endtask

    // Hasher model and output monitor; every transfer is judged at the falling edge.
    always @(negedge clk) begin
        if (dif.done) done_cnt++;
        if (dif.hash_read) begin
            rd_count++;
            rd_cyc_q.push_back(cyc);
            chk("read_expected", 256'(exp_rd_q.size() != 0), 1);
            if (exp_rd_q.size() != 0) begin
                mon_nonce = exp_rd_q.pop_front();
                chk("read_nonce", dif.hash_in[HW+NW-1:HW], mon_nonce);
                chk("read_header", dif.hash_in[HW-1:0], cur_hdr);
            end
            $display("read  cyc=%0d nonce=%08h", cyc, dif.hash_in[HW+NW-1:HW]);
            pend_q.push_back('{cyc + LAT, dif.hash_in[HW+NW-1:HW]});
        end
        if (dif.found_valid && dif.found_ready) begin
            found_cnt++;
            chk("found_expected", 256'(exp_found_q.size() != 0), 1);
            if (exp_found_q.size() != 0) begin
                mon_found = exp_found_q.pop_front();
                chk("found_nonce", dif.found_nonce, mon_found.nonce);
                chk("found_hash_hi", dif.found_hash_hi, mon_found.hi);
            end
            $display("found cyc=%0d nonce=%08h hi=%016h", cyc, dif.found_nonce, dif.found_hash_hi);
        end
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            dif.hash_write = 1'b1;
            dif.hash_out   = dig(pend_q[0].nonce);
            void'(pend_q.pop_front());
        end else begin
            dif.hash_write = 1'b0;
            dif.hash_out   = '0;
        end
    end

    task automatic run_job(input logic [31:0] start, input logic [31:0] count,
                           input logic [63:0] target, input int n_reads);
        int t;
        t = 0;
        while (!dif.job_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("job_ready", dif.job_ready, 1);
        cur_hdr = {7{$urandom()}};
        for (int i = 0; i < n_reads; i++) exp_rd_q.push_back(start + 32'(i));
        dif.job_header      = cur_hdr;
        dif.job_nonce_start = start;
        dif.job_nonce_count = count;
        dif.job_target      = target;
        dif.job_valid       = 1'b1;
        acc_cyc = cyc;
        rd_base = rd_count;
        rd_cyc_q.delete();
        @(negedge clk);
        dif.job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((dif.busy || pend_q.size() != 0 || dif.hash_write) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_in_time", 256'(t < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_reads(input int n);
        int t;
        t = 0;
        while (rd_count < rd_base + n && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reads_in_time", 256'(t < 500), 1);
    endtask

    int d0, f0;
    logic [255:0] dref;

    initial begin
        dif.job_valid = 1'b0;
        dif.job_header = '0;
        dif.job_nonce_start = '0;
        dif.job_nonce_count = '0;
        dif.job_target = '0;
        dif.found_ready = 1'b1;
`ifdef KECCAK_DISPATCH_ABORT_EN
        dif.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", dif.busy, 0);
        chk("rst_job_ready", dif.job_ready, 0);
        chk("rst_hash_read", dif.hash_read, 0);
        chk("rst_found_valid", dif.found_valid, 0);
        chk("rst_drop", dif.drop_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", dif.job_ready, 1);

        // Target 0: no hits, read cadence +1/+11/+21.
        d0 = done_cnt; f0 = found_cnt;
        run_job(32'h100, 32'd3, 64'd0, 3);
        wait_idle();
        chk("t1_nreads", rd_cyc_q.size(), 3);
        for (int i = 0; i < rd_cyc_q.size() && i < 3; i++)
            chk("t1_read_offset", rd_cyc_q[i] - acc_cyc, 1 + TP * i);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_nofound", found_cnt - f0, 0);
        chk("t1_busy", dif.busy, 0);
        chk("t1_rd_left", exp_rd_q.size(), 0);

        // Target max: every digest is a hit.
        d0 = done_cnt;
        push_found(32'h100); push_found(32'h101);
        run_job(32'h100, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_idle();
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_found_left", exp_found_q.size(), 0);

        // Target equal to one digest's upper word: the <= boundary.
        dref = dig(32'h101);
        for (int i = 0; i < 3; i++) begin
            logic [255:0] dd;
            dd = dig(32'h100 + 32'(i));
            if (dd[255:192] <= dref[255:192]) push_found(32'h100 + 32'(i));
        end
        run_job(32'h100, 32'd3, dref[255:192], 3);
        wait_idle();
        chk("t2b_found_left", exp_found_q.size(), 0);

        // Found FIFO held full: two kept, two dropped.
        dif.found_ready = 1'b0;
        push_found(32'h100); push_found(32'h101);
        run_job(32'h100, 32'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        wait_idle();
        chk("t3_drop", dif.drop_count, 2);
        chk("t3_valid_held", dif.found_valid, 1);
        chk("t3_head_held", dif.found_nonce, 32'h100);
        dif.found_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_found_left", exp_found_q.size(), 0);
        chk("t3_valid_clear", dif.found_valid, 0);

        // Nonce wrap.
        run_job(32'hFFFF_FFFF, 32'd2, 64'd0, 2);
        wait_idle();
        chk("t4_rd_left", exp_rd_q.size(), 0);

        // Reset mid-job: late digests become drops.
        d0 = done_cnt; f0 = found_cnt;
        run_job(32'h200, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_reads(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", dif.busy, 0);
        chk("t5_hash_read", dif.hash_read, 0);
        chk("t5_job_ready", dif.job_ready, 0);
        chk("t5_drop_clr", dif.drop_count, 0);
        chk("t5_found_valid", dif.found_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle();
        chk("t5_drop", dif.drop_count, 2);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_found", found_cnt - f0, 0);
        chk("t5_rd_left", exp_rd_q.size(), 0);

`ifdef KECCAK_DISPATCH_ABORT_EN
        // Abort after the third read: remaining results still checked.
        d0 = done_cnt;
        push_found(32'h300); push_found(32'h301); push_found(32'h302);
        run_job(32'h300, 32'd100, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        wait_reads(3);
        #2 dif.abort = 1'b1;
        @(negedge clk);
        dif.abort = 1'b0;
        wait_idle();
        chk("t6_reads", rd_count - rd_base, 3);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_found_left", exp_found_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/keccak_nonce_dispatcher.md
Name: keccak_nonce_dispatcher

Overview:
- Drives a Keccak-f[800] pipelined hasher and consumes its results. Issues one nonce per `THROUGHPUT`-clock slot on the hasher's `in`/`read` side.
- Tracks in-flight nonces and compares each returned 256-bit hash against a 64-bit target on the `out`/`write` side.
- Reports winning nonces upstream over a valid/ready interface. Sits between the job/host interface and the hasher instance.

Parameters:
- THROUGHPUT, 10, clocks per hash slot; must equal the connected hasher's `THROUGHPUT`.
- HDR_WIDTH, 224, job header bits placed in hasher input bits [HDR_WIDTH-1:0].
- NONCE_WIDTH, 32, nonce bits placed in hasher input bits [HDR_WIDTH+NONCE_WIDTH-1:HDR_WIDTH].
- TAG_DEPTH, 8, in-flight nonce FIFO depth, power of two; must be >= ceil(hasher latency / THROUGHPUT) + 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- job_valid  in  1  job offered.
- job_ready  out  1  job accepted when valid & ready.
- job_header  in  HDR_WIDTH  header constant for the job.
- job_nonce_start  in  NONCE_WIDTH  first nonce.
- job_nonce_count  in  NONCE_WIDTH  number of nonces to hash.
- job_target  in  64  hit threshold.
- hash_in  out  HDR_WIDTH+NONCE_WIDTH  hasher input, {nonce, header}.
- hash_read  out  1  one-cycle hasher load strobe.
- hash_out  in  256  hasher digest.
- hash_write  in  1  digest valid strobe, no backpressure.
- found_valid  out  1  hit available.
- found_ready  in  1  hit consumed when valid & ready.
- found_nonce  out  NONCE_WIDTH  nonce of hit.
- found_hash_hi  out  64  hash_out[255:192] of hit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job completion.
- drop_count  out  8  saturating count of lost hits and spurious digests.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: all outputs 0, FSM=IDLE, FIFOs empty, drop_count=0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - job_ready=1.
  - On job_valid, latch header, nonce (=start), remaining (=count), target.
  - count!=0 -> RUN.
  - count==0 -> pulse done next cycle, stay IDLE.
- RUN:
  - job_ready=0.
  - Slot counter 0..THROUGHPUT-1, reset to 0 on job accept.
  - The first hash_read is asserted in the cycle after acceptance, then exactly every THROUGHPUT cycles. THROUGHPUT=1 means every cycle.
  - hash_in is registered and valid in the same cycle as hash_read.
  - On each read: push nonce to tag FIFO, nonce+1 (wraps mod 2^NONCE_WIDTH), remaining-1.
  - When remaining hits 0 after a read -> DRAIN.
  - If the tag FIFO is full at a slot, that slot is skipped (no read). The slot counter keeps running so the cadence stays aligned.
- DRAIN:
  - No reads.
  - When the tag FIFO is empty and no write is arriving this cycle -> IDLE, done=1 for one cycle.
- hash_write:
  - Pop the tag FIFO; the popped nonce pairs with hash_out.
  - Hit iff hash_out[255:192] <= job_target, unsigned.
  - Compare and pop in the same cycle as hash_write.
  - If hit, push {nonce, hash_hi} into the 2-entry found FIFO.
  - Simultaneous tag push (read) and pop (write) in one cycle is legal; occupancy is unchanged.
- Spurious write (hash_write with tag FIFO empty, e.g. after reset mid-job while the hasher pipeline drains): ignored, drop_count+1.
- Found FIFO full when a hit arrives: hit lost, drop_count+1.
  - A pop by found_ready in the same cycle frees space first, so the hit is kept.
- drop_count saturates at 255 and clears only on rst.
- found_valid = found FIFO non-empty. found_nonce/found_hash_hi show the head entry. Head is stable while valid & !ready.
- rst mid-operation: immediate return to IDLE with all FIFOs flushed. No done pulse.

Optional Feature:
- Macro: KECCAK_DISPATCH_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in RUN -> no further reads from the next cycle, remaining forced to 0, -> DRAIN.
  - Results of already issued nonces are still checked and reported. done pulses as normal.
  - abort in IDLE or DRAIN has no effect.
- When undefined: no port; jobs always run to completion.

Test Plan:
- THROUGHPUT=10, start=0x100, count=3, target=0 -> hash_read at cycles +1, +11, +21 with nonces 0x100, 0x101, 0x102. After three writes: done pulse, no found_valid, busy low.
- target=64'hFFFF_FFFF_FFFF_FFFF, count=2, found_ready=1 -> two found_valid beats with found_nonce 0x100, then 0x101, and the correct found_hash_hi each.
- target=max, count=4, found_ready=0 -> two entries buffered, drop_count=2. Release found_ready -> nonces 0x100, 0x101 delivered in order.
- start=0xFFFF_FFFF, count=2 -> nonces 0xFFFF_FFFF then 0x0000_0000.
- Assert rst after the 2nd read of a 5-nonce job -> outputs 0 immediately. The hasher's 2 late writes each raise drop_count (ends at 2). No found_valid, no done.
- KECCAK_DISPATCH_ABORT_EN defined, count=100, abort after 3rd read -> exactly 3 reads, 3 results checked, done pulse after last write.
